request_resolver_8259: RTL and testbench

REQUEST_RESOLVER_8259 -- requirements
Module: request_resolver_8259

---
 rtl/pic8259_pkg.sv | 37 +++
 rtl/priority_resolver_8259.sv | 36 +++
 rtl/request_resolver_8259.sv | 128 ++++++++++++
 tb/tb_request_resolver_8259.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pic8259_pkg.sv
// Shared 8259 types and helpers: acknowledge-sequence states and the
// rotate / isolate primitives used by the request and in-service stages.
package pic8259_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK1  = 2'd1,
    ST_WAIT2 = 2'd2,
    ST_ACK2  = 2'd3
  } ack_state_t;

  // Rotate an 8-bit level vector right by n positions.
  function automatic logic [7:0] rotate_right(input logic [7:0] v, input logic [2:0] n);
    return (v >> n) | (v << (4'd8 - {1'b0, n}));
  endfunction

  // Rotate an 8-bit level vector left by n positions.
  function automatic logic [7:0] rotate_left(input logic [7:0] v, input logic [2:0] n);
    return (v << n) | (v >> (4'd8 - {1'b0, n}));
  endfunction

  // Keep only the lowest set bit (bit 0 is the highest priority after rotation).
  function automatic logic [7:0] resolv_priority(input logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction

  // Encode a one-hot level vector into its 3-bit level number.
  function automatic logic [2:0] onehot_to_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/priority_resolver_8259.sv
// Combinational priority resolver: masks IRR, picks the highest-priority
// pending level under rotation and compares it with the level in service.
module priority_resolver_8259
  import pic8259_pkg::*;
(
  input  logic [7:0] interrupt_request_register,
  input  logic [7:0] interrupt_mask,
  input  logic [2:0] priority_rotate,
  input  logic [7:0] highest_level_in_service,
  output logic [7:0] resolved_request,
  output logic       request_pending,
  output logic       interrupt_wanted
);

  logic [2:0] shift;
  logic [7:0] masked_request;
  logic [7:0] request_rot;
  logic [7:0] service_rot;

  // Highest-priority level (rotate+1) lands on bit 0 after rotating right.
  assign shift = priority_rotate + 3'd1;

  // Resolve the winner and decide whether it should interrupt the CPU.
  always_comb begin
    masked_request   = interrupt_request_register & ~interrupt_mask;
    request_rot      = resolv_priority(rotate_right(masked_request, shift));
    service_rot      = resolv_priority(rotate_right(highest_level_in_service, shift));
    resolved_request = rotate_left(request_rot, shift);
    request_pending  = |request_rot;
    // Both vectors are one-hot in the rotated domain: a smaller value means
    // a higher priority, so a plain magnitude compare is "strictly higher".
    interrupt_wanted = request_pending &&
                       ((service_rot == 8'd0) || (request_rot < service_rot));
  end

endmodule

// File: rtl/request_resolver_8259.sv
// 8259 request stage: IRR capture, priority resolution, INTA# sequencing,
// vector drive and AEOI pulse generation.
//
// Strobe semantics toward the in-service stage: latch_in_service is a
// single-cycle valid with no back-pressure; interrupt is meaningful only
// while it is high. end_of_interrupt is likewise a one-cycle pulse and the
// two never coincide. vector_out is meaningful only while vector_enable is 1.
module request_resolver_8259
  import pic8259_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] interrupt_request_pin,
  input  logic       level_or_edge_triggering,
  input  logic [7:0] interrupt_mask,
  input  logic [2:0] priority_rotate,
  input  logic [7:0] highest_level_in_service,
  input  logic       interrupt_acknowledge_n,
  input  logic       auto_eoi,
  input  logic [4:0] vector_base,
  output logic       interrupt_out,
  output logic       latch_in_service,
  output logic [7:0] interrupt,
  output logic [7:0] end_of_interrupt,
  output logic [7:0] vector_out,
  output logic       vector_enable,
  output logic [7:0] interrupt_request_register,
  output ack_state_t debug_state
);

  logic [7:0] pin_q;
  logic       inta_q;
  logic [7:0] irr_next;
  ack_state_t state, state_next;
  logic [2:0] level;
  logic       spurious;
  logic [7:0] resolved_request;
  logic       request_pending;
  logic       interrupt_wanted;
  logic       inta_fall;
  logic       inta_rise;
  logic       ack_start;
  logic       grant;

  priority_resolver_8259 u_resolver (
    .interrupt_request_register (interrupt_request_register),
    .interrupt_mask             (interrupt_mask),
    .priority_rotate            (priority_rotate),
    .highest_level_in_service   (highest_level_in_service),
    .resolved_request           (resolved_request),
    .request_pending            (request_pending),
    .interrupt_wanted           (interrupt_wanted)
  );

  assign inta_fall   = inta_q & ~interrupt_acknowledge_n;
  assign inta_rise   = ~inta_q & interrupt_acknowledge_n;
  assign ack_start   = (state == ST_IDLE) && inta_fall;
  assign grant       = ack_start && request_pending;
  assign debug_state = state;

  // Acknowledge sequence: two INTA# pulses, vector driven during the second.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (inta_fall) state_next = ST_ACK1;
      ST_ACK1:  if (inta_rise) state_next = ST_WAIT2;
      ST_WAIT2: if (inta_fall) state_next = ST_ACK2;
      ST_ACK2:  if (inta_rise) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // IRR update: edge or level capture, then the grant clear overrides any set.
  always_comb begin
    irr_next = interrupt_request_register;
    for (int i = 0; i < 8; i++) begin
      if (level_or_edge_triggering)
        irr_next[i] = interrupt_request_pin[i];
      else if (!pin_q[i] && interrupt_request_pin[i])
        irr_next[i] = 1'b1;
      else if (!interrupt_request_pin[i])
        irr_next[i] = 1'b0;
    end
    if (grant) irr_next = irr_next & ~resolved_request;
  end

  // State, IRR, frozen level and registered strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                      <= ST_IDLE;
      pin_q                      <= '0;
      inta_q                     <= 1'b1;
      interrupt_request_register <= '0;
      level                      <= '0;
      spurious                   <= 1'b0;
      latch_in_service           <= 1'b0;
      interrupt                  <= '0;
      interrupt_out              <= 1'b0;
    end else begin
      state                      <= state_next;
      pin_q                      <= interrupt_request_pin;
      inta_q                     <= interrupt_acknowledge_n;
      interrupt_request_register <= irr_next;
      latch_in_service           <= grant;
      interrupt                  <= grant ? resolved_request : 8'd0;
      // INT stays low for the whole acknowledge sequence.
      interrupt_out              <= (state_next == ST_IDLE) && interrupt_wanted;
      if (ack_start) begin
        level    <= request_pending ? onehot_to_index(resolved_request) : 3'd7;
        spurious <= ~request_pending;
      end
    end
  end

  // Vector drive during ACK2 and the AEOI pulse on the closing INTA# rise.
  always_comb begin
    vector_enable    = 1'b0;
    vector_out       = '0;
    end_of_interrupt = '0;
    if (state == ST_ACK2) begin
      vector_enable = 1'b1;
      vector_out    = {vector_base, level};
      if (inta_rise && auto_eoi && !spurious)
        end_of_interrupt = 8'd1 << level;
    end
  end

endmodule

// File: tb/tb_request_resolver_8259.sv
// Bench for request_resolver_8259: directed scenarios plus randomized
// acknowledge transactions checked by a queue-based scoreboard.
module tb_request_resolver_8259;
  import pic8259_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] interrupt_request_pin;
  logic       level_or_edge_triggering;
  logic [7:0] interrupt_mask;
  logic [2:0] priority_rotate;
  logic [7:0] highest_level_in_service;
  logic       interrupt_acknowledge_n;
  logic       auto_eoi;
  logic [4:0] vector_base;
  logic       interrupt_out;
  logic       latch_in_service;
  logic [7:0] interrupt;
  logic [7:0] end_of_interrupt;
  logic [7:0] vector_out;
  logic       vector_enable;
  logic [7:0] interrupt_request_register;
  ack_state_t debug_state;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_latch_q[$];
  logic [7:0] exp_vec_q[$];
  logic [7:0] exp_eoi_q[$];

  request_resolver_8259 dut (
    .clock                      (clock),
    .reset                      (reset),
    .interrupt_request_pin      (interrupt_request_pin),
    .level_or_edge_triggering   (level_or_edge_triggering),
    .interrupt_mask             (interrupt_mask),
    .priority_rotate            (priority_rotate),
    .highest_level_in_service   (highest_level_in_service),
    .interrupt_acknowledge_n    (interrupt_acknowledge_n),
    .auto_eoi                   (auto_eoi),
    .vector_base                (vector_base),
    .interrupt_out              (interrupt_out),
    .latch_in_service           (latch_in_service),
    .interrupt                  (interrupt),
    .end_of_interrupt           (end_of_interrupt),
    .vector_out                 (vector_out),
    .vector_enable              (vector_enable),
    .interrupt_request_register (interrupt_request_register),
    .debug_state                (debug_state)
  );

  // Clock
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Reference model: walk levels from highest priority to lowest.
  function automatic int model_winner(input logic [7:0] irr, input logic [7:0] mask,
                                      input logic [2:0] rot);
    for (int k = 1; k <= 8; k++) begin
      int l;
      l = (int'(rot) + k) % 8;
      if (irr[l] && !mask[l]) return l;
    end
    return -1;
  endfunction

  // Priority rank of a level: 0 is highest, 7 is lowest (= rot).
  function automatic int model_rank(input int l, input logic [2:0] rot);
    return (l - int'(rot) + 7) % 8;
  endfunction

  function automatic int isr_level(input logic [7:0] isr);
    for (int i = 0; i < 8; i++) if (isr[i]) return i;
    return -1;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a strobe or vector.
  logic ve_prev = 1'b0;
  always @(negedge clock) begin
    if (latch_in_service || (end_of_interrupt != 8'd0))
      check("latch_eoi_exclusive", {7'd0, latch_in_service & (|end_of_interrupt)}, 8'd0);
    if (latch_in_service) begin
      if (exp_latch_q.size() == 0) check("latch_unexpected", {7'd0, latch_in_service}, 8'd0);
      else check("latch_interrupt", interrupt, exp_latch_q.pop_front());
    end
    if (vector_enable && !ve_prev) begin
      if (exp_vec_q.size() == 0) check("vector_unexpected", {7'd0, vector_enable}, 8'd0);
      else check("vector_out", vector_out, exp_vec_q.pop_front());
    end
    if (end_of_interrupt != 8'd0) begin
      if (exp_eoi_q.size() == 0) check("eoi_unexpected", end_of_interrupt, 8'd0);
      else check("end_of_interrupt", end_of_interrupt, exp_eoi_q.pop_front());
    end
    ve_prev = vector_enable;
  end

  task automatic inta_pulse();
    interrupt_acknowledge_n = 1'b0;
    tick(2);
    interrupt_acknowledge_n = 1'b1;
    tick(2);
  endtask

  // One full transaction: load requests, check INT, run the INTA pair.
  task automatic run_txn(input logic mode, input logic [7:0] p, input logic [7:0] mask,
                         input logic [2:0] rot, input logic [7:0] isr, input logic aeoi,
                         input logic [4:0] vb, input logic disturb);
    int w;
    logic [7:0] g;
    logic exp_int;
    level_or_edge_triggering = mode;
    interrupt_mask           = mask;
    priority_rotate          = rot;
    highest_level_in_service = isr;
    auto_eoi                 = aeoi;
    vector_base              = vb;
    interrupt_request_pin    = 8'd0;
    tick(2);
    interrupt_request_pin = p;
    tick(3);
    check("irr_loaded", interrupt_request_register, p);
    w = model_winner(p, mask, rot);
    exp_int = (w >= 0) && ((isr == 8'd0) || (model_rank(w, rot) < model_rank(isr_level(isr), rot)));
    check("interrupt_out", {7'd0, interrupt_out}, {7'd0, exp_int});
    g = (w >= 0) ? 8'(1 << w) : 8'd0;
    if (w >= 0) exp_latch_q.push_back(g);
    exp_vec_q.push_back({vb, (w >= 0) ? 3'(w) : 3'd7});
    if (aeoi && (w >= 0)) exp_eoi_q.push_back(g);
    interrupt_acknowledge_n = 1'b0;
    tick(2);
    check("state_ack1", 8'(debug_state), 8'(ST_ACK1));
    if (disturb) begin
      interrupt_mask  = 8'($urandom);
      priority_rotate = 3'($urandom_range(0, 7));
    end
    interrupt_acknowledge_n = 1'b1;
    tick(2);
    interrupt_acknowledge_n = 1'b0;
    tick(2);
    check("int_out_in_ack2", {7'd0, interrupt_out}, 8'd0);
    interrupt_acknowledge_n = 1'b1;
    tick(2);
    check("irr_after_ack", interrupt_request_register, mode ? p : (p & ~g));
    check("state_idle", 8'(debug_state), 8'(ST_IDLE));
  endtask

  // Stimulus
  initial begin
    reset                    = 1'b1;
    interrupt_request_pin    = 8'd0;
    level_or_edge_triggering = 1'b0;
    interrupt_mask           = 8'd0;
    priority_rotate          = 3'd7;
    highest_level_in_service = 8'd0;
    interrupt_acknowledge_n  = 1'b1;
    auto_eoi                 = 1'b0;
    vector_base              = 5'd0;
    tick(3);
    check("reset_irr", interrupt_request_register, 8'd0);
    check("reset_int_out", {7'd0, interrupt_out}, 8'd0);
    check("reset_vector_out", vector_out, 8'd0);
    check("reset_state", 8'(debug_state), 8'(ST_IDLE));
    reset = 1'b0;
    tick(2);

    // IR3 edge: IRR next cycle, INT one cycle after that.
    interrupt_request_pin = 8'h08;
    tick(1);
    check("ir3_irr", interrupt_request_register, 8'h08);
    check("ir3_int_early", {7'd0, interrupt_out}, 8'd0);
    tick(1);
    check("ir3_int", {7'd0, interrupt_out}, 8'd1);

    // IR2+IR5, base 0x10: grant IR2, vector 0x82, IR5 left pending.
    run_txn(1'b0, 8'h24, 8'h00, 3'd7, 8'h00, 1'b0, 5'h10, 1'b0);
    // rotate=2: IR4 beats IR1.
    run_txn(1'b0, 8'h12, 8'h00, 3'd2, 8'h00, 1'b0, 5'h03, 1'b1);
    // IR6 blocked by IR2 in service, then released.
    run_txn(1'b0, 8'h40, 8'h00, 3'd7, 8'h04, 1'b0, 5'h07, 1'b0);
    interrupt_request_pin = 8'd0;
    tick(2);
    interrupt_request_pin = 8'h40;
    tick(3);
    check("ir6_blocked", {7'd0, interrupt_out}, 8'd0);
    highest_level_in_service = 8'd0;
    tick(1);
    check("ir6_released", {7'd0, interrupt_out}, 8'd1);
    // Spurious ack with AEOI on: vector level 7, no latch, no EOI.
    run_txn(1'b0, 8'h00, 8'h00, 3'd7, 8'h00, 1'b1, 5'h15, 1'b0);
    // IR0 with AEOI: EOI 0x01 on the second rise.
    run_txn(1'b0, 8'h01, 8'h00, 3'd7, 8'h00, 1'b1, 5'h02, 1'b0);

    // Reset in WAIT2 aborts the sequence; the next INTA# starts afresh.
    interrupt_request_pin = 8'd0;
    tick(2);
    interrupt_request_pin = 8'h02;
    tick(3);
    exp_latch_q.push_back(8'h02);
    inta_pulse();
    check("abort_state_wait2", 8'(debug_state), 8'(ST_WAIT2));
    interrupt_request_pin = 8'd0;
    reset = 1'b1;
    #2;
    check("abort_state", 8'(debug_state), 8'(ST_IDLE));
    check("abort_irr", interrupt_request_register, 8'd0);
    check("abort_vector_enable", {7'd0, vector_enable}, 8'd0);
    check("abort_eoi", end_of_interrupt, 8'd0);
    tick(2);
    reset = 1'b0;
    tick(2);
    inta_pulse();
    check("after_abort_wait2", 8'(debug_state), 8'(ST_WAIT2));
    exp_vec_q.push_back({vector_base, 3'd7});
    inta_pulse();

    // Randomized transactions in both trigger modes.
    for (int t = 0; t < 30; t++) begin
      logic [7:0] isr;
      isr = ($urandom_range(0, 1) == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'd0;
      run_txn(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom & $urandom),
              3'($urandom_range(0, 7)), isr, 1'($urandom_range(0, 1)),
              5'($urandom), 1'b1);
    end

    tick(5);
    check("latch_q_drained", 8'(exp_latch_q.size()), 8'd0);
    check("vec_q_drained", 8'(exp_vec_q.size()), 8'd0);
    check("eoi_q_drained", 8'(exp_eoi_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
